// File: rtl/debug_step_ctrl.sv
// Single-step / breakpoint controller: debounces a step pushbutton and gates
// the processor clock enable for free run, single step and address breakpoints.
module debug_step_ctrl #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned ADDR_W          = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              key_step_n,
  input  logic              run_mode,
  input  logic              bp_enable,
  input  logic [ADDR_W-1:0] bp_addr,
  input  logic [ADDR_W-1:0] instr_addr,
  output logic              cpu_clk_en,
  output logic              halted,
  output logic              at_break,
  output logic [31:0]       cycle_count
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_HALT  = 2'd0,
    S_RUN   = 2'd1,
    S_STEP  = 2'd2,
    S_BREAK = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             sync1_q, sync2_q;
  logic             key_lvl_q, key_lvl_d;
  logic [CNT_W-1:0] db_cnt_q, db_cnt_d;
  logic [31:0]      cycle_count_q, cycle_count_d;
  logic             key_accept;
  logic             step_pulse;
  logic             bp_hit;

  // Counter only runs while the synchronized key disagrees with the accepted
  // level, so any bounce back to the old level clears it.
  always_comb begin
    key_lvl_d  = key_lvl_q;
    db_cnt_d   = '0;
    key_accept = 1'b0;
    if (sync2_q != key_lvl_q) begin
      if (db_cnt_q == CNT_LAST) begin
        key_lvl_d  = sync2_q;
        key_accept = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + CNT_W'(1);
      end
    end
  end

  assign step_pulse = key_accept & ~sync2_q & ~reset;
  assign bp_hit     = bp_enable & (instr_addr == bp_addr);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_HALT: begin
        if (run_mode)        state_d = S_RUN;
        else if (step_pulse) state_d = S_STEP;
      end
      S_STEP: state_d = S_HALT;
      S_RUN: begin
        if (!run_mode)       state_d = S_HALT;
        else if (bp_hit)     state_d = S_BREAK;
      end
      S_BREAK: begin
        if (!run_mode)       state_d = S_HALT;
        else if (step_pulse) state_d = S_STEP;
      end
      default: state_d = S_HALT;
    endcase
  end

  // Stop is zero-latency: the instruction sitting at the breakpoint never advances.
  assign cpu_clk_en    = ((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP);
  assign halted        = (state_q == S_HALT) || (state_q == S_BREAK);
  assign at_break      = (state_q == S_BREAK);
  assign cycle_count_d = cpu_clk_en ? cycle_count_q + 32'd1 : cycle_count_q;
  assign cycle_count   = cycle_count_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= S_HALT;
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      key_lvl_q     <= 1'b1;
      db_cnt_q      <= '0;
      cycle_count_q <= 32'd0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= key_step_n;
      sync2_q       <= sync1_q;
      key_lvl_q     <= key_lvl_d;
      db_cnt_q      <= db_cnt_d;
      cycle_count_q <= cycle_count_d;
    end
  end

endmodule

// File: doc/debug_step_ctrl.md
DEBUG_STEP_CTRL -- requirements
Module: debug_step_ctrl

Interface
REQ-001 SHALL provide parameter DEBOUNCE_CYCLES, default 1000000 (20 ms at 50 MHz): cycles the synchronized key must be stable before it is accepted.
REQ-002 SHALL provide parameter ADDR_W, default 32: width of the instruction and breakpoint addresses.
REQ-003 SHALL have one clock and a synchronous active-high reset.
REQ-004 SHALL provide port clk, input, 1: the single clock (CLOCK_50 domain).
REQ-005 SHALL provide port reset, input, 1: synchronous, active-high.
REQ-006 SHALL provide port key_step_n, input, 1: raw pushbutton, active-low, asynchronous to clk.
REQ-007 SHALL provide port run_mode, input, 1: level; 1 = free run, 0 = single-step.
REQ-008 SHALL provide port bp_enable, input, 1: breakpoint compare enable.
REQ-009 SHALL provide port bp_addr, input, ADDR_W: breakpoint address.
REQ-010 SHALL provide port instr_addr, input, ADDR_W: current fetch address from the processor.
REQ-011 SHALL provide port cpu_clk_en, output, 1: clock enable that gates the processor's advance.
REQ-012 SHALL provide port halted, output, 1: high in HALT or BREAK.
REQ-013 SHALL provide port at_break, output, 1: high in BREAK.
REQ-014 SHALL provide port cycle_count, output, 32: count of enabled processor cycles.

Function
REQ-015 SHALL synchronize key_step_n through two flip-flops, each reset to 1.
REQ-016 SHALL debounce the synchronized key as follows: the counter clears on any change; the new level is accepted only after DEBOUNCE_CYCLES consecutive stable cycles.
REQ-017 SHALL generate a one-cycle step_pulse on the accepted 1->0 transition only; a held key SHALL NOT repeat and release SHALL NOT pulse.
REQ-018 SHALL implement FSM states HALT, RUN, STEP and BREAK.
REQ-019 In HALT: if run_mode=1, go to RUN; else if step_pulse, go to STEP; run_mode has priority and a coincident pulse is discarded.
REQ-020 In STEP: go to HALT unconditionally after exactly one cycle.
REQ-021 In RUN: if run_mode=0, go to HALT; else if bp_hit, go to BREAK; step_pulse is ignored.
REQ-022 In BREAK: if run_mode=0, go to HALT; else if step_pulse, go to STEP.
REQ-023 After a step out of BREAK, the controller SHALL return to HALT and resume RUN on the next cycle when run_mode=1.
REQ-024 SHALL define bp_hit = bp_enable AND (instr_addr == bp_addr), full ADDR_W compare, combinational.
REQ-025 cpu_clk_en SHALL be combinational: (state==RUN AND NOT bp_hit) OR state==STEP, so the matching instruction is not advanced (zero-latency stop).
REQ-026 halted = state in {HALT, BREAK}; at_break = (state==BREAK).
REQ-027 cycle_count SHALL increment by 1 on every clk edge where cpu_clk_en=1, wrapping 0xFFFFFFFF -> 0 with no saturation.
REQ-028 On simultaneous run_mode=0 and bp_hit in RUN, the controller SHALL go to HALT, not BREAK.
REQ-029 bp_enable=0 SHALL fully suppress breakpoints, including while in RUN.

Reset
REQ-030 On reset=1 at a clk edge, the block SHALL set: state=HALT, cpu_clk_en=0, halted=1, at_break=0, cycle_count=0, debounce counter=0, accepted key level=1, sync flops=1.
REQ-031 Reset SHALL override all other inputs, including mid-STEP and mid-debounce; no step_pulse SHALL be emitted in the reset cycle or the first cycle after it.
REQ-032 A key held low through reset release SHALL produce exactly one step_pulse, DEBOUNCE_CYCLES+2 cycles after release.

Verification (DEBOUNCE_CYCLES=4)
REQ-033 Step: run_mode=0, key low for 10 cycles -> exactly one cpu_clk_en cycle; cycle_count 0->1; halted returns to 1.
REQ-034 Bounce: key toggled every 2 cycles for 20 cycles, then high -> no step_pulse; cycle_count stays 0.
REQ-035 Breakpoint: bp_enable=1, bp_addr=0x40, run_mode=1, instr_addr incrementing by 4 from 0 each enabled cycle -> BREAK with instr_addr=0x40, cycle_count=16, cpu_clk_en=0 in the match cycle.
REQ-036 Step past break: from REQ-035, key press -> one enabled cycle (instr_addr->0x44), then HALT, then RUN; cycle_count continues 17, 18, ...
REQ-037 Priority and wrap: preload cycle_count=0xFFFFFFFF via a force, RUN one cycle -> 0; then run_mode=0 with bp_hit in the same cycle -> HALT, at_break=0.
REQ-038 Reset mid-RUN: assert reset for 1 cycle -> next cycle state=HALT, cycle_count=0, cpu_clk_en=0.
